// File: rtl/muldiv_engine.sv
`default_nettype none
// ============================================================================
// muldiv_engine : multi-cycle multiply/divide unit owning architectural HI/LO
// Revision 1.0
// ============================================================================
module muldiv_engine #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             capture;
    logic             commit;

    // Result of the incoming request, formatted as {hi, lo}
    logic [63:0]      result;
    logic             result_wr;
    logic             is_arith;
    logic [CNT_W-1:0] load_cnt;

    logic [63:0]      pending;
    logic             pending_wr;

    logic             a_neg;
    logic             b_neg;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic             div_by_zero;
    logic [31:0]      divisor_s;
    logic [31:0]      divisor_u;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      q_signed;
    logic [31:0]      r_signed;
    logic [31:0]      q_unsigned;
    logic [31:0]      r_unsigned;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             wr_hi;
    logic             wr_lo;

    // Signed division works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN
    always_comb begin
        a_neg       = src_a[31];
        b_neg       = src_b[31];
        a_mag       = a_neg ? (~src_a + 32'd1) : src_a;
        b_mag       = b_neg ? (~src_b + 32'd1) : src_b;
        div_by_zero = (src_b == 32'd0);
        divisor_s   = div_by_zero ? 32'd1 : b_mag;
        divisor_u   = div_by_zero ? 32'd1 : src_b;
        q_mag       = a_mag / divisor_s;
        r_mag       = a_mag % divisor_s;
        q_signed    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        r_signed    = a_neg ? (~r_mag + 32'd1) : r_mag;
        q_unsigned  = src_a / divisor_u;
        r_unsigned  = src_a % divisor_u;
        prod_s      = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u      = {32'd0, src_a} * {32'd0, src_b};
    end

    always_comb begin
        result    = 64'd0;
        result_wr = 1'b0;
        is_arith  = 1'b0;
        load_cnt  = MULT_CNT;
        case (md_op)
            OP_MULT: begin
                result    = prod_s;
                result_wr = 1'b1;
                is_arith  = 1'b1;
            end
            OP_MULTU: begin
                result    = prod_u;
                result_wr = 1'b1;
                is_arith  = 1'b1;
            end
            OP_DIV: begin
                result    = {r_signed, q_signed};
                result_wr = !div_by_zero;
                is_arith  = 1'b1;
                load_cnt  = DIV_CNT;
            end
            OP_DIVU: begin
                result    = {r_unsigned, q_unsigned};
                result_wr = !div_by_zero;
                is_arith  = 1'b1;
                load_cnt  = DIV_CNT;
            end
            default: begin
                result    = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_arith) begin
                    state_nxt = RUN;
                    count_nxt = load_cnt;
                    capture   = 1'b1;
                end
            end
            RUN: begin
                count_nxt = count - CNT_ONE;
                if (count == CNT_ONE) begin
                    state_nxt = IDLE;
                    commit    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy  = (state == RUN);
    assign wr_hi = (state == IDLE) && start && (md_op == OP_MTHI);
    assign wr_lo = (state == IDLE) && start && (md_op == OP_MTLO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= 64'd0;
            pending_wr <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            if (capture) begin
                pending    <= result;
                pending_wr <= result_wr;
            end
            // Commit only happens in RUN and moves happen only in IDLE, so they never collide
            if (commit && pending_wr) begin
                hi <= pending[63:32];
                lo <= pending[31:0];
            end else begin
                if (wr_hi) begin
                    hi <= src_a;
                end
                if (wr_lo) begin
                    lo <= src_a;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_engine.sv
`default_nettype none
// Directed testbench for muldiv_engine with hand-computed HI/LO results.
module tb_muldiv_engine;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_errors;

    muldiv_engine #(
        .MULT_LAT (5),
        .DIV_LAT  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue an arithmetic op at a negedge and count busy cycles; returns at the first non-busy negedge.
    // If inject >= 1, an mthi 0xDEAD strobe is driven during that busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject, output int cycles);
        int cnt;
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        cnt   = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (cnt == inject) begin
                start = 1'b1;
                md_op = OP_MTHI;
                src_a = 32'h0000_DEAD;
            end else begin
                start = 1'b0;
                md_op = OP_NONE;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        md_op  = OP_NONE;
        cycles = cnt;
    endtask

    task automatic single(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
    endtask

    initial begin
        int cyc;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        start = 1'b0;
        md_op = OP_NONE;
        src_a = 32'd0;
        src_b = 32'd0;

        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(OP_MULT, 32'd7, 32'd6, 0, cyc);
        check("mult7x6_lat", cyc, 32'd5);
        check("mult7x6_hi", hi, 32'd0);
        check("mult7x6_lo", lo, 32'd42);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0, cyc);
        check("mult_neg_lat", cyc, 32'd5);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, cyc);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, cyc);
        check("div_m7_2_lat", cyc, 32'd10);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi", hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd7, 0, cyc);
        check("divu_lat", cyc, 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        single(OP_MTHI, 32'h11);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h11);
        single(OP_MTLO, 32'h22);
        check("mtlo_lo", lo, 32'h22);
        check("mtlo_hi_kept", hi, 32'h11);

        single(OP_NONE, 32'h99);
        single(OP_RSVD, 32'h77);
        check("noop_busy", {31'd0, busy}, 32'd0);
        check("noop_hi", hi, 32'h11);
        check("noop_lo", lo, 32'h22);

        run_op(OP_DIV, 32'd5, 32'd0, 0, cyc);
        check("div0_lat", cyc, 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        run_op(OP_MULT, 32'd3, 32'd5, 2, cyc);
        check("ignored_lat", cyc, 32'd5);
        check("ignored_hi", hi, 32'd0);
        check("ignored_lo", lo, 32'd15);

        run_op(OP_MULT, 32'd4, 32'd4, 0, cyc);
        check("b2b_mult_lat", cyc, 32'd5);
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        check("b2b_mult_lo", lo, 32'd16);
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, cyc);
        check("b2b_div_lat", cyc, 32'd10);
        check("b2b_div_lo", lo, 32'hFFFF_FFF2);
        check("b2b_div_hi", hi, 32'hFFFF_FFFE);

        single(OP_MTHI, 32'h55);
        start = 1'b1;
        md_op = OP_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = OP_NONE;
        repeat (2) @(negedge clk);
        check("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_nocommit_busy", {31'd0, busy}, 32'd0);
        check("rst_nocommit_hi", hi, 32'd0);
        check("rst_nocommit_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
